csi2tx_comp_line_ctrl: RTL and testbench

- Sequences the 12-to-8 DPCM compressor datapath (encoder/decoder/predictor with registered encoded-byte output) per frame and per line.
- Latches the compression scheme at frame start and meters sensor pixels into the compressor under downstream backpressure.
- Inserts a predictor-flush gap between lines, counts pixels and bytes, and flags malformed line lengths.
- Sits between the sensor pixel interface and the CSI-2 packet builder.

---
 rtl/csi2tx_comp_line_ctrl.sv | 158 +++++++++++++++
 tb/tb_csi2tx_comp_line_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi2tx_comp_line_ctrl.sv
// Line/frame sequencer for the 12-to-8 DPCM compressor: latches scheme and line
// length per frame, meters pixels under backpressure and inserts a predictor-flush gap.
module csi2tx_comp_line_ctrl #(
    parameter int unsigned PIX_W   = 12,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned GAP_CYC = 4
) (
    input  logic             sensor_clk,
    input  logic             sys_rst_n,
    input  logic [4:0]       cfg_comp_scheme,
    input  logic [CNT_W-1:0] cfg_line_pixels,
    input  logic             frame_start,
    input  logic             line_start,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_in_valid,
    output logic             pix_in_ready,
    output logic [4:0]       comp_scheme,
    output logic             comp_enable,
    output logic [PIX_W-1:0] comp_pixel_data,
    output logic             comp_pixel_valid,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             line_done,
    output logic [CNT_W-1:0] line_byte_cnt,
    output logic             err_short_line,
    output logic             err_long_line,
    input  logic             err_clr
);

    localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {IDLE, WAIT_LS, ACTIVE, GAP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] line_len;
    logic [CNT_W-1:0] pix_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             pending;
    logic             line_seen;
    logic             advance;
    logic             in_active;
    logic             accept;
    logic             last_accept;
    logic             byte_taken;
    logic             start_line;
    logic             enter_gap;
    logic             short_evt;
    logic             long_evt;
    logic             pend_set;

    assign advance    = out_ready | ~out_valid;
    assign in_active  = (state == ACTIVE);
    assign byte_taken = out_valid & out_ready;

    // IDLE is only reachable through reset, so freezing the compressor there
    // keeps every output at zero while out of a frame.
    assign comp_enable = advance & (state != IDLE);

    assign pix_in_ready     = in_active & advance & (pix_cnt < line_len);
    assign accept           = pix_in_valid & pix_in_ready;
    assign comp_pixel_valid = accept;
    assign comp_pixel_data  = in_active ? pix_in : '0;
    assign last_accept      = accept & (pix_cnt == line_len - 1'b1);

    always_comb begin
        state_nxt  = state;
        start_line = 1'b0;
        enter_gap  = 1'b0;
        short_evt  = 1'b0;
        long_evt   = 1'b0;
        pend_set   = 1'b0;
        case (state)
            IDLE: begin
            end
            WAIT_LS: begin
                long_evt = pix_in_valid & line_seen;
                if (line_start) begin
                    start_line = 1'b1;
                    state_nxt  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (line_start) begin
                    pend_set  = 1'b1;
                    short_evt = ~last_accept;
                end
                if (line_start | last_accept) begin
                    enter_gap = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (line_start) pend_set = 1'b1;
                if (advance && gap_cnt == GAP_W'(1)) begin
                    // a line_start remembered during abort/gap skips WAIT_LS
                    if (pending | line_start) begin
                        start_line = 1'b1;
                        state_nxt  = ACTIVE;
                    end else begin
                        state_nxt = WAIT_LS;
                    end
                end
            end
        endcase
        if (frame_start) state_nxt = WAIT_LS;
    end

    always_ff @(posedge sensor_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= IDLE;
            comp_scheme    <= '0;
            line_len       <= CNT_W'(1);
            pix_cnt        <= '0;
            gap_cnt        <= '0;
            pending        <= 1'b0;
            line_seen      <= 1'b0;
            out_valid      <= 1'b0;
            line_byte_cnt  <= '0;
            line_done      <= 1'b0;
            err_short_line <= 1'b0;
            err_long_line  <= 1'b0;
        end else begin
            state          <= state_nxt;
            if (advance) out_valid <= comp_pixel_valid;
            line_done      <= byte_taken & (line_byte_cnt == line_len - 1'b1);
            err_short_line <= short_evt | (err_short_line & ~err_clr);
            err_long_line  <= long_evt | (err_long_line & ~err_clr);

            if (frame_start) begin
                comp_scheme   <= cfg_comp_scheme;
                line_len      <= (cfg_line_pixels == '0) ? CNT_W'(1) : cfg_line_pixels;
                pix_cnt       <= '0;
                line_byte_cnt <= '0;
                gap_cnt       <= '0;
                pending       <= 1'b0;
                line_seen     <= 1'b0;
            end else begin
                if (start_line) begin
                    pix_cnt       <= '0;
                    line_byte_cnt <= '0;
                    pending       <= 1'b0;
                    line_seen     <= 1'b0;
                end else begin
                    if (accept)     pix_cnt       <= pix_cnt + 1'b1;
                    if (byte_taken) line_byte_cnt <= line_byte_cnt + 1'b1;
                    if (pend_set)   pending       <= 1'b1;
                    if (state == GAP && state_nxt == WAIT_LS) line_seen <= 1'b1;
                end
                if (enter_gap) begin
                    gap_cnt <= GAP_W'(GAP_CYC);
                end else if (state == GAP && advance) begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_csi2tx_comp_line_ctrl.sv
// Directed table-driven bench for csi2tx_comp_line_ctrl, plus hand sequences
// for asynchronous reset mid-line and a fresh frame afterwards.
module tb_csi2tx_comp_line_ctrl;

    logic        sensor_clk;
    logic        sys_rst_n;
    logic [4:0]  cfg_comp_scheme;
    logic [15:0] cfg_line_pixels;
    logic        frame_start;
    logic        line_start;
    logic [11:0] pix_in;
    logic        pix_in_valid;
    logic        pix_in_ready;
    logic [4:0]  comp_scheme;
    logic        comp_enable;
    logic [11:0] comp_pixel_data;
    logic        comp_pixel_valid;
    logic        out_ready;
    logic        out_valid;
    logic        line_done;
    logic [15:0] line_byte_cnt;
    logic        err_short_line;
    logic        err_long_line;
    logic        err_clr;

    csi2tx_comp_line_ctrl #(.PIX_W(12), .CNT_W(16), .GAP_CYC(4)) dut (
        .sensor_clk       (sensor_clk),
        .sys_rst_n        (sys_rst_n),
        .cfg_comp_scheme  (cfg_comp_scheme),
        .cfg_line_pixels  (cfg_line_pixels),
        .frame_start      (frame_start),
        .line_start       (line_start),
        .pix_in           (pix_in),
        .pix_in_valid     (pix_in_valid),
        .pix_in_ready     (pix_in_ready),
        .comp_scheme      (comp_scheme),
        .comp_enable      (comp_enable),
        .comp_pixel_data  (comp_pixel_data),
        .comp_pixel_valid (comp_pixel_valid),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .line_done        (line_done),
        .line_byte_cnt    (line_byte_cnt),
        .err_short_line   (err_short_line),
        .err_long_line    (err_long_line),
        .err_clr          (err_clr)
    );

    initial sensor_clk = 1'b0;
    always #5 sensor_clk = ~sensor_clk;

    typedef struct packed {
        logic        rdy;
        logic        cpv;
        logic        en;
        logic        ov;
        logic        ld;
        logic        es;
        logic        el;
        logic [4:0]  sch;
        logic [15:0] bcnt;
        logic [11:0] data;
    } out_t;

    typedef struct {
        logic        fs;
        logic        ls;
        logic        pv;
        logic        ordy;
        logic        clr;
        logic [4:0]  cs;
        logic [15:0] cp;
        logic [11:0] pix;
        out_t        exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_err;

    // sticky context used while filling the table
    logic [4:0]  c_cs;
    logic [15:0] c_cp;
    logic        c_es;
    logic        c_el;
    logic [4:0]  c_sch;

    task automatic add(input logic fs, input logic ls, input logic pv, input logic [11:0] pix,
                       input logic ordy, input logic clr,
                       input logic rdy, input logic cpv, input logic en, input logic ov,
                       input logic ld, input int bcnt, input logic [11:0] dat);
        vec_t v;
        v.fs = fs; v.ls = ls; v.pv = pv; v.pix = pix; v.ordy = ordy; v.clr = clr;
        v.cs = c_cs; v.cp = c_cp;
        v.exp.rdy = rdy; v.exp.cpv = cpv; v.exp.en = en; v.exp.ov = ov; v.exp.ld = ld;
        v.exp.es = c_es; v.exp.el = c_el; v.exp.sch = c_sch;
        v.exp.bcnt = 16'(bcnt); v.exp.data = dat;
        vecs.push_back(v);
    endtask

    function automatic out_t snap();
        out_t o;
        o.rdy = pix_in_ready; o.cpv = comp_pixel_valid; o.en = comp_enable;
        o.ov = out_valid; o.ld = line_done; o.es = err_short_line; o.el = err_long_line;
        o.sch = comp_scheme; o.bcnt = line_byte_cnt; o.data = comp_pixel_data;
        return o;
    endfunction

    task automatic drive(input vec_t v);
        frame_start = v.fs; line_start = v.ls; pix_in_valid = v.pv; pix_in = v.pix;
        out_ready = v.ordy; err_clr = v.clr; cfg_comp_scheme = v.cs; cfg_line_pixels = v.cp;
    endtask

    task automatic idle_inputs();
        frame_start = 1'b0; line_start = 1'b0; pix_in_valid = 1'b0; pix_in = '0;
        out_ready = 1'b1; err_clr = 1'b0;
    endtask

    task automatic chk_out(input string name, input out_t got, input out_t want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h (rdy cpv en ov ld es el sch bcnt data)", name, got, want);
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        c_es = 1'b0; c_el = 1'b0; c_sch = '0; c_cs = 5'd2; c_cp = 16'd8;
        // line 1: scheme 2, 8 pixels, no backpressure
        add(1,0,0,0,1,0, 0,0,0,0,0,0,0);
        c_sch = 5'd2;
        add(0,1,0,0,1,0, 0,0,1,0,0,0,0);
        for (int i = 0; i < 8; i++)
            add(0,0,1,12'(256 + i),1,0, 1,1,1,(i > 0),0,(i > 0 ? i - 1 : 0),12'(256 + i));
        add(0,0,0,0,1,0, 0,0,1,1,0,7,0);
        add(0,0,0,0,1,0, 0,0,1,0,1,8,0);
        add(0,0,0,0,1,0, 0,0,1,0,0,8,0);
        add(0,0,0,0,1,0, 0,0,1,0,0,8,0);
        // stray pixel in WAIT_LS after a finished line, then clear
        add(0,0,1,12'hABC,1,0, 0,0,1,0,0,8,0);
        c_el = 1'b1;
        add(0,0,0,0,1,0, 0,0,1,0,0,8,0);
        add(0,0,0,0,1,1, 0,0,1,0,0,8,0);
        c_el = 1'b0;
        add(0,1,0,0,1,0, 0,0,1,0,0,8,0);
        // line 2 with a 5-cycle stall after 4 pixels
        for (int i = 0; i < 4; i++)
            add(0,0,1,12'(512 + i),1,0, 1,1,1,(i > 0),0,(i > 0 ? i - 1 : 0),12'(512 + i));
        for (int i = 0; i < 5; i++)
            add(0,0,1,12'(516),0,0, 0,0,0,1,0,3,12'(516));
        for (int i = 4; i < 8; i++)
            add(0,0,1,12'(512 + i),1,0, 1,1,1,1,0,i - 1,12'(512 + i));
        // line_start one cycle after the last pixel: 4-cycle gap then straight to line 3
        add(0,1,0,0,1,0, 0,0,1,1,0,7,0);
        add(0,0,0,0,1,0, 0,0,1,0,1,8,0);
        add(0,0,0,0,1,0, 0,0,1,0,0,8,0);
        add(0,0,0,0,1,0, 0,0,1,0,0,8,0);
        // line 3 aborted after 5 pixels
        for (int i = 0; i < 5; i++)
            add(0,0,1,12'(768 + i),1,0, 1,1,1,(i > 0),0,(i > 0 ? i - 1 : 0),12'(768 + i));
        add(0,1,0,0,1,0, 1,0,1,1,0,4,0);
        c_es = 1'b1;
        for (int i = 0; i < 4; i++)
            add(0,0,0,0,1,0, 0,0,1,0,0,5,0);
        // line 4 full length; mid-frame cfg changes are ignored
        c_cs = 5'd3; c_cp = 16'd4;
        for (int i = 0; i < 8; i++)
            add(0,0,1,12'(1024 + i),1,0, 1,1,1,(i > 0),0,(i > 0 ? i - 1 : 0),12'(1024 + i));
        add(0,0,0,0,1,1, 0,0,1,1,0,7,0);
        c_es = 1'b0;
        add(0,0,0,0,1,0, 0,0,1,0,1,8,0);
        add(0,0,0,0,1,0, 0,0,1,0,0,8,0);
        add(0,0,0,0,1,0, 0,0,1,0,0,8,0);
        // new frame: scheme 3, 3-pixel lines
        c_cp = 16'd3;
        add(1,0,0,0,1,0, 0,0,1,0,0,8,0);
        c_sch = 5'd3;
        add(0,1,0,0,1,0, 0,0,1,0,0,0,0);
        for (int i = 0; i < 3; i++)
            add(0,0,1,12'(1280 + i),1,0, 1,1,1,(i > 0),0,(i > 0 ? i - 1 : 0),12'(1280 + i));
        add(0,0,0,0,1,0, 0,0,1,1,0,2,0);
        add(0,0,0,0,1,0, 0,0,1,0,1,3,0);
        add(0,0,0,0,1,0, 0,0,1,0,0,3,0);
        add(0,0,0,0,1,0, 0,0,1,0,0,3,0);
        // new frame with line_pixels = 0, treated as 1
        c_cs = 5'd2; c_cp = 16'd0;
        add(1,0,0,0,1,0, 0,0,1,0,0,3,0);
        c_sch = 5'd2;
        add(0,1,0,0,1,0, 0,0,1,0,0,0,0);
        add(0,0,1,12'h7FF,1,0, 1,1,1,0,0,0,12'h7FF);
        add(0,0,1,12'h001,1,0, 0,0,1,1,0,0,0);
        add(0,0,0,0,1,0, 0,0,1,0,1,1,0);
        add(0,0,0,0,1,0, 0,0,1,0,0,1,0);
        add(0,0,0,0,1,0, 0,0,1,0,0,1,0);

        // reset state, with active-looking inputs present
        sys_rst_n = 1'b0;
        cfg_comp_scheme = 5'd7; cfg_line_pixels = 16'd8;
        frame_start = 1'b1; line_start = 1'b1; pix_in_valid = 1'b1; pix_in = 12'hFFF;
        out_ready = 1'b1; err_clr = 1'b0;
        @(negedge sensor_clk);
        @(negedge sensor_clk);
        #1;
        chk_out("reset_state", snap(), '0);
        @(negedge sensor_clk);
        idle_inputs();
        sys_rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge sensor_clk);
            drive(vecs[i]);
            #1;
            chk_out($sformatf("vec%0d", i), snap(), vecs[i].exp);
        end

        // asynchronous reset after 3 pixels of a line
        @(negedge sensor_clk);
        idle_inputs();
        frame_start = 1'b1; cfg_comp_scheme = 5'd5; cfg_line_pixels = 16'd8;
        @(negedge sensor_clk);
        frame_start = 1'b0; line_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sensor_clk);
            line_start = 1'b0; pix_in_valid = 1'b1; pix_in = 12'(1536 + i);
        end
        @(negedge sensor_clk);
        pix_in = 12'(1539);
        #1;
        chk("pre_rst_out_valid", int'(out_valid), 1);
        chk("pre_rst_byte_cnt", int'(line_byte_cnt), 2);
        chk("pre_rst_scheme", int'(comp_scheme), 5);
        sys_rst_n = 1'b0;
        #1;
        chk_out("async_reset_mid_line", snap(), '0);
        @(negedge sensor_clk);
        idle_inputs();
        @(negedge sensor_clk);
        sys_rst_n = 1'b1;

        // fresh frame after reset
        begin
            int sent, bytes, dones;
            sent = 0; bytes = 0; dones = 0;
            @(negedge sensor_clk);
            frame_start = 1'b1; cfg_comp_scheme = 5'd2; cfg_line_pixels = 16'd8;
            @(negedge sensor_clk);
            frame_start = 1'b0; line_start = 1'b1;
            @(negedge sensor_clk);
            line_start = 1'b0;
            for (int c = 0; c < 30; c++) begin
                pix_in_valid = (sent < 8);
                pix_in = 12'(1792 + sent);
                #1;
                if (pix_in_valid && pix_in_ready) sent++;
                if (out_valid && out_ready) bytes++;
                if (line_done) dones++;
                @(negedge sensor_clk);
            end
            pix_in_valid = 1'b0;
            #1;
            chk("post_rst_pixels", sent, 8);
            chk("post_rst_bytes", bytes, 8);
            chk("post_rst_line_done", dones, 1);
            chk("post_rst_byte_cnt", int'(line_byte_cnt), 8);
            chk("post_rst_scheme", int'(comp_scheme), 2);
            chk("post_rst_errs", int'({err_short_line, err_long_line}), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
